// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register: owns the PC, applies branch/stall/jump
// priority each edge and keeps saturating fetch/stall counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_en,
  input  logic [1:0]       pcsource,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_inst,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc4,
  output logic             id_valid,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] PCS_BR = 2'b01;
  localparam logic [1:0] PCS_J  = 2'b10;

  logic [31:0]      r_pc;
  logic [31:0]      r_id_inst;
  logic [31:0]      r_id_pc4;
  logic             r_id_valid;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [31:0] w_pc4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_tgt = branch_target & ~32'd3;
  // Jump is formed from the instruction currently sitting in IF/ID.
  assign w_j_tgt  = {r_id_pc4[31:28], r_id_inst[25:0], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_id_inst   <= 32'h0;
      r_id_pc4    <= 32'h0;
      r_id_valid  <= 1'b0;
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (pcsource == PCS_BR) begin
      // Branch resolves in mem and wins even over a stall.
      r_pc       <= w_br_tgt;
      r_id_inst  <= 32'h0;
      r_id_pc4   <= 32'h0;
      r_id_valid <= 1'b0;
    end else if (stall_en) begin
      if (~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else if (pcsource == PCS_J) begin
      r_pc       <= w_j_tgt;
      r_id_inst  <= 32'h0;
      r_id_pc4   <= 32'h0;
      r_id_valid <= 1'b0;
    end else begin
      r_pc       <= w_pc4;
      r_id_inst  <= imem_inst;
      r_id_pc4   <= w_pc4;
      r_id_valid <= 1'b1;
      if (~&r_fetch_cnt) r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
    end
  end

  assign imem_addr = r_pc;
  assign id_inst   = r_id_inst;
  assign id_pc4    = r_id_pc4;
  assign id_valid  = r_id_valid;
  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, branch/jump
// redirect, PC wrap, and counter saturation on a narrow-counter twin.
module tb_fetch_stage;
  logic        clk;
  logic        rst;
  logic        stall_en;
  logic [1:0]  pcsource;
  logic [31:0] branch_target;
  logic [31:0] imem_addr, imem_inst;
  logic [31:0] id_inst, id_pc4;
  logic        id_valid;
  logic [31:0] fetch_cnt, stall_cnt;

  logic [31:0] s_imem_addr, s_id_inst, s_id_pc4, s_imem_inst;
  logic        s_id_valid;
  logic [1:0]  s_fetch_cnt, s_stall_cnt;

  logic [31:0] rom0, rom4, rom8;
  int n_vec, n_err;

  fetch_stage #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall_en(stall_en), .pcsource(pcsource),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .id_inst(id_inst), .id_pc4(id_pc4), .id_valid(id_valid),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  // Same stimulus, 2-bit counters so saturation is reachable.
  fetch_stage #(.RESET_PC(32'h0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .stall_en(stall_en), .pcsource(pcsource),
    .branch_target(branch_target), .imem_addr(s_imem_addr), .imem_inst(s_imem_inst),
    .id_inst(s_id_inst), .id_pc4(s_id_pc4), .id_valid(s_id_valid),
    .fetch_cnt(s_fetch_cnt), .stall_cnt(s_stall_cnt)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0)      return rom0;
    else if (a == 32'h4) return rom4;
    else if (a == 32'h8) return rom8;
    else                 return {16'hA5A5, a[15:0]};
  endfunction

  assign imem_inst   = rom(imem_addr);
  assign s_imem_inst = rom(s_imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rom0 = 32'h1111_0001; rom4 = 32'h2222_0002; rom8 = 32'h3333_0003;
    rst = 1'b1; stall_en = 1'b0; pcsource = 2'b00; branch_target = 32'h0;
    #12;
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_inst",  id_inst, 32'h0);
    chk("rst_fcnt",  fetch_cnt, 32'h0);
    rst = 1'b0;

    // T2 sequential
    step();
    chk("seq1_inst", id_inst, 32'h1111_0001);
    chk("seq1_pc4",  id_pc4, 32'h4);
    chk("seq1_addr", imem_addr, 32'h4);
    chk("seq1_vld",  {31'h0, id_valid}, 32'h1);
    step();
    chk("seq2_inst", id_inst, 32'h2222_0002);
    chk("seq2_pc4",  id_pc4, 32'h8);
    chk("seq2_addr", imem_addr, 32'h8);
    chk("seq2_fcnt", fetch_cnt, 32'd2);

    // T3 stall for three cycles
    stall_en = 1'b1;
    repeat (3) step();
    chk("stl_addr", imem_addr, 32'h8);
    chk("stl_inst", id_inst, 32'h2222_0002);
    chk("stl_pc4",  id_pc4, 32'h8);
    chk("stl_scnt", stall_cnt, 32'd3);
    chk("stl_fcnt", fetch_cnt, 32'd2);
    stall_en = 1'b0;
    step();
    chk("rel_inst", id_inst, 32'h3333_0003);
    chk("rel_pc4",  id_pc4, 32'hC);
    chk("rel_fcnt", fetch_cnt, 32'd3);
    chk("sat_f3",   {30'h0, s_fetch_cnt}, 32'd3);

    // T4 branch beats stall, low bits dropped
    stall_en = 1'b1; pcsource = 2'b01; branch_target = 32'h43;
    step();
    chk("br_addr", imem_addr, 32'h40);
    chk("br_vld",  {31'h0, id_valid}, 32'h0);
    chk("br_inst", id_inst, 32'h0);
    chk("br_scnt", stall_cnt, 32'd3);
    pcsource = 2'b00;
    step();
    chk("scnt4",   stall_cnt, 32'd4);
    chk("sat_s",   {30'h0, s_stall_cnt}, 32'd3);
    stall_en = 1'b0;
    repeat (2) step();
    chk("fcnt5",   fetch_cnt, 32'd5);
    chk("sat_f",   {30'h0, s_fetch_cnt}, 32'd3);

    // T1 async reset mid-run (no edge needed)
    rst = 1'b1;
    #1;
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_vld",  {31'h0, id_valid}, 32'h0);
    chk("arst_inst", id_inst, 32'h0);
    chk("arst_fcnt", fetch_cnt, 32'h0);
    chk("arst_scnt", stall_cnt, 32'h0);
    rom4 = 32'h4800_0010;
    #2 rst = 1'b0;

    // T5 jump, first held by stall then taken
    repeat (2) step();
    chk("j_inst", id_inst, 32'h4800_0010);
    chk("j_pc4",  id_pc4, 32'h8);
    pcsource = 2'b10; stall_en = 1'b1;
    step();
    chk("jst_addr", imem_addr, 32'h8);
    chk("jst_inst", id_inst, 32'h4800_0010);
    chk("jst_scnt", stall_cnt, 32'd1);
    stall_en = 1'b0;
    step();
    chk("j_addr", imem_addr, 32'h40);
    chk("j_vld",  {31'h0, id_valid}, 32'h0);
    chk("j_bpc4", id_pc4, 32'h0);
    pcsource = 2'b00;
    step();
    chk("jn_inst", id_inst, 32'hA5A5_0040);
    chk("jn_pc4",  id_pc4, 32'h44);
    chk("jn_fcnt", fetch_cnt, 32'd3);

    // T6 PC wrap
    pcsource = 2'b01; branch_target = 32'hFFFF_FFFF;
    step();
    chk("w_addr", imem_addr, 32'hFFFF_FFFC);
    pcsource = 2'b11;
    step();
    chk("w_pc",   imem_addr, 32'h0);
    chk("w_pc4",  id_pc4, 32'h0);
    chk("w_inst", id_inst, 32'hA5A5_FFFC);
    chk("w_vld",  {31'h0, id_valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
